keyvalue_initiator: RTL and testbench

Wishbone initiator that drives a `keyvalue_3`-style key/value store target. It turns simple PUT/GET commands from a local valid/ready command port into single classic Wishbone cycles, with bus timeout protection. It returns each result (value, duplicate flag, error) on a held valid/ready response port and keeps saturating transaction statistics. It sits between a host-side sequencer (e.g. IO-pin or LA driven logic) and the store's target port.

---
 rtl/keyvalue_initiator.sv | 121 ++++++++++++
 tb/tb_keyvalue_initiator.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/keyvalue_initiator.sv
// keyvalue_initiator: turns PUT/GET commands into single classic Wishbone
// cycles towards a key/value store target. Each cycle ends with an ACK or
// a timeout. The result is held on a response port, and saturating
// ok/error counters are kept.
//
// Handshakes: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. A response transfers on a rising edge where
// rsp_valid and rsp_ready are both high. Once rsp_valid is raised, it and
// the rsp_* fields stay stable until that transfer happens.
module keyvalue_initiator #(
  parameter int TIMEOUT = 255,
  parameter int STAT_W  = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_1,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [15:0]       cmd_key,
  input  logic [15:0]       cmd_value,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [15:0]       rsp_data,
  output logic              rsp_dup,
  output logic              rsp_err,
  output logic              CYC_o,
  output logic              STB_o,
  output logic              WE_o,
  output logic              ADR_IS_KEY_o,
  output logic              DAT_IS_KEY_o,
  output logic [31:0]       ADR_o,
  output logic [31:0]       DAT_o,
  input  logic              ACK_i,
  input  logic [15:0]       DAT_i,
  input  logic              DUP_i,
  output logic [STAT_W-1:0] stat_ok,
  output logic [STAT_W-1:0] stat_err
);

  typedef enum logic [1:0] {IDLE, BUS, RSP} state_t;

  localparam logic [15:0]       TLAST = 16'(TIMEOUT - 1);
  localparam logic [STAT_W-1:0] SMAX  = '1;

  state_t      state;
  logic [15:0] tcnt;

  // Single FSM: every output is a register updated alongside the state.
  // cmd_ready resets low and rises on the first edge after reset is released.
  always_ff @(posedge sys_clk or negedge sys_rst_1) begin
    if (!sys_rst_1) begin
      state        <= IDLE;
      tcnt         <= '0;
      cmd_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_dup      <= 1'b0;
      rsp_err      <= 1'b0;
      CYC_o        <= 1'b0;
      STB_o        <= 1'b0;
      WE_o         <= 1'b0;
      ADR_IS_KEY_o <= 1'b0;
      DAT_IS_KEY_o <= 1'b0;
      ADR_o        <= '0;
      DAT_o        <= '0;
      stat_ok      <= '0;
      stat_err     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            state        <= BUS;
            cmd_ready    <= 1'b0;
            tcnt         <= '0;
            CYC_o        <= 1'b1;
            STB_o        <= 1'b1;
            WE_o         <= cmd_op;
            ADR_IS_KEY_o <= 1'b1;
            DAT_IS_KEY_o <= 1'b0;
            ADR_o        <= {16'h0, cmd_key};
            DAT_o        <= {16'h0, cmd_value};
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        BUS: begin
          // ACK wins even on the last allowed cycle.
          if (ACK_i || (tcnt == TLAST)) begin
            state        <= RSP;
            CYC_o        <= 1'b0;
            STB_o        <= 1'b0;
            ADR_IS_KEY_o <= 1'b0;
            rsp_valid    <= 1'b1;
            if (ACK_i) begin
              rsp_data <= DAT_i;
              rsp_dup  <= DUP_i;
              rsp_err  <= 1'b0;
              if (stat_ok != SMAX) stat_ok <= stat_ok + 1'b1;
            end else begin
              rsp_data <= '0;
              rsp_dup  <= 1'b0;
              rsp_err  <= 1'b1;
              if (stat_err != SMAX) stat_err <= stat_err + 1'b1;
            end
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keyvalue_initiator.sv
// Directed bench for keyvalue_initiator. Runs a main instance (STAT_W=16)
// and a narrow instance (STAT_W=2) side by side on the same stimulus.
module tb_keyvalue_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_op, rsp_ready, ACK_i, DUP_i;
  logic [15:0] cmd_key, cmd_value, DAT_i;

  logic        cmd_ready, rsp_valid, rsp_dup, rsp_err;
  logic [15:0] rsp_data;
  logic        CYC_o, STB_o, WE_o, ADR_IS_KEY_o, DAT_IS_KEY_o;
  logic [31:0] ADR_o, DAT_o;
  logic [15:0] stat_ok, stat_err;

  logic        n_cmd_ready, n_rsp_valid, n_rsp_dup, n_rsp_err;
  logic [15:0] n_rsp_data;
  logic        n_cyc, n_stb, n_we, n_aik, n_dik;
  logic [31:0] n_adr, n_dat;
  logic [1:0]  n_stat_ok, n_stat_err;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_ok = 0;
  int exp_err = 0;

  keyvalue_initiator #(.TIMEOUT(4), .STAT_W(16)) dut (
    .sys_clk(clk), .sys_rst_1(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_key(cmd_key), .cmd_value(cmd_value),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_dup(rsp_dup), .rsp_err(rsp_err),
    .CYC_o(CYC_o), .STB_o(STB_o), .WE_o(WE_o),
    .ADR_IS_KEY_o(ADR_IS_KEY_o), .DAT_IS_KEY_o(DAT_IS_KEY_o),
    .ADR_o(ADR_o), .DAT_o(DAT_o),
    .ACK_i(ACK_i), .DAT_i(DAT_i), .DUP_i(DUP_i),
    .stat_ok(stat_ok), .stat_err(stat_err)
  );

  keyvalue_initiator #(.TIMEOUT(4), .STAT_W(2)) dut_narrow (
    .sys_clk(clk), .sys_rst_1(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(n_cmd_ready), .cmd_op(cmd_op),
    .cmd_key(cmd_key), .cmd_value(cmd_value),
    .rsp_valid(n_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(n_rsp_data),
    .rsp_dup(n_rsp_dup), .rsp_err(n_rsp_err),
    .CYC_o(n_cyc), .STB_o(n_stb), .WE_o(n_we),
    .ADR_IS_KEY_o(n_aik), .DAT_IS_KEY_o(n_dik),
    .ADR_o(n_adr), .DAT_o(n_dat),
    .ACK_i(ACK_i), .DAT_i(DAT_i), .DUP_i(DUP_i),
    .stat_ok(n_stat_ok), .stat_err(n_stat_err)
  );

  // Clock: 10 time-unit period.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_stats();
    check("stat_ok", 32'(stat_ok), 32'(exp_ok));
    check("stat_err", 32'(stat_err), 32'(exp_err));
    check("narrow_stat_ok", 32'(n_stat_ok), 32'((exp_ok > 3) ? 3 : exp_ok));
  endtask

  // One command. ack_at is the STB cycle index (0-based) that sees ACK_i,
  // or -1 for no ACK. hold is the number of cycles rsp_ready stays low.
  task automatic txn(input logic op, input logic [15:0] key, input logic [15:0] val,
                     input int ack_at, input logic [15:0] rdat, input logic rdup,
                     input int hold, input int exp_stb);
    int guard;
    int stb_cycles;
    logic [15:0] exp_data;
    logic        exp_dup, exp_e;
    guard = 0;
    while (!cmd_ready && guard < 20) begin
      tick();
      guard++;
    end
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_key = key; cmd_value = val;
    tick();
    cmd_valid = 1'b0;
    check("bus_cyc", 32'(CYC_o), 32'd1);
    check("bus_we", 32'(WE_o), 32'(op));
    check("bus_adr", ADR_o, {16'h0, key});
    check("bus_dat", DAT_o, {16'h0, val});
    check("bus_adr_is_key", 32'(ADR_IS_KEY_o), 32'd1);
    check("bus_dat_is_key", 32'(DAT_IS_KEY_o), 32'd0);
    check("cmd_ready_bus", 32'(cmd_ready), 32'd0);
    stb_cycles = 0;
    for (int i = 0; i < 16; i++) begin
      if (!STB_o) break;
      stb_cycles++;
      ACK_i = (i == ack_at);
      DAT_i = rdat;
      DUP_i = rdup;
      tick();
      ACK_i = 1'b0;
    end
    check("stb_cycles", 32'(stb_cycles), 32'(exp_stb));
    if (ack_at >= 0) begin
      exp_data = rdat; exp_dup = rdup; exp_e = 1'b0; exp_ok++;
    end else begin
      exp_data = 16'h0; exp_dup = 1'b0; exp_e = 1'b1; exp_err++;
    end
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_cyc_low", 32'(CYC_o), 32'd0);
    // Stray ACKs with changed read data while the response is held.
    for (int h = 0; h < hold; h++) begin
      ACK_i = 1'b1;
      DAT_i = 16'hDEAD;
      DUP_i = ~rdup;
      tick();
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      check("hold_data", 32'(rsp_data), 32'(exp_data));
    end
    ACK_i = 1'b0;
    check("rsp_data", 32'(rsp_data), 32'(exp_data));
    check("rsp_dup", 32'(rsp_dup), 32'(exp_dup));
    check("rsp_err", 32'(rsp_err), 32'(exp_e));
    check_stats();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    check("cmd_ready_after_rsp", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_key = '0; cmd_value = '0;
    rsp_ready = 1'b0; ACK_i = 1'b0; DAT_i = '0; DUP_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_cyc_stb", 32'({CYC_o, STB_o, WE_o, ADR_IS_KEY_o, DAT_IS_KEY_o}), 32'd0);
    check("rst_adr", ADR_o, 32'd0);
    check("rst_dat", DAT_o, 32'd0);
    check("rst_rsp", 32'({rsp_valid, rsp_dup, rsp_err, rsp_data}), 32'd0);
    check_stats();
    rst_n = 1'b1;
    tick();
    check("rel_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rel_cyc", 32'(CYC_o), 32'd0);

    // PUT, ACK one cycle after STB rises.
    txn(1'b1, 16'h00A5, 16'h1234, 1, 16'h1234, 1'b0, 0, 2);
    // WE_o holds its last value outside BUS.
    check("we_hold", 32'(WE_o), 32'd1);
    // GET, 3 wait cycles (ACK on the 4th = final timeout cycle), response held 5 cycles.
    txn(1'b0, 16'h00A5, 16'h0000, 3, 16'h1234, 1'b1, 5, 4);
    // Timeout with no ACK.
    txn(1'b0, 16'h0042, 16'h0000, -1, 16'hBEEF, 1'b1, 0, 4);

    // Stray ACK in IDLE: no bus cycle, no count.
    ACK_i = 1'b1;
    tick();
    tick();
    ACK_i = 1'b0;
    check("idle_ack_cyc", 32'(CYC_o), 32'd0);
    check("idle_ack_ready", 32'(cmd_ready), 32'd1);
    check("idle_ack_rsp", 32'(rsp_valid), 32'd0);
    check_stats();

    // Back-to-back commands, varied patterns.
    txn(1'b1, 16'h0001, 16'h1111, 0, 16'h0001, 1'b0, 0, 1);
    txn(1'b0, 16'hFFFF, 16'h0000, 2, 16'hA5A5, 1'b1, 0, 3);
    txn(1'b1, 16'h8000, 16'hFFFF, 0, 16'h5A5A, 1'b0, 0, 1);

    // Async reset while STB_o is high.
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_key = 16'h0077; cmd_value = 16'h0099;
    tick();
    cmd_valid = 1'b0;
    check("pre_rst_stb", 32'(STB_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_cyc_stb", 32'({CYC_o, STB_o}), 32'd0);
    ACK_i = 1'b1;
    tick();
    ACK_i = 1'b0;
    rst_n = 1'b1;
    exp_ok = 0;
    exp_err = 0;
    tick();
    tick();
    check_stats();
    check("post_rst_rsp", 32'(rsp_valid), 32'd0);

    // Five successes: narrow instance saturates at 3.
    for (int t = 0; t < 5; t++) begin
      txn(t[0], 16'(16'h0100 + t), 16'(16'h0200 + t), t % 2, 16'(16'h0300 + t), 1'b0, 0, (t % 2) + 1);
    end
    check("narrow_sat", 32'(n_stat_ok), 32'd3);
    check("wide_ok_5", 32'(stat_ok), 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Hard time limit so the bench never hangs.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
